// File: rtl/ymf262_rx.sv
`timescale 1ns/1ps
// YMF262 (OPL3) serial DAC-port receiver: oversampled DCLK/SMP/DO, MSB-first 16-bit words per channel.
// Optional mono mix output is built only when YMRX_MIX_EN is defined.
module ymf262_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ym_dclk,
    input  logic [1:0]  ym_smp,
    input  logic        ym_data,
    output logic [15:0] sample_a,
    output logic [15:0] sample_b,
    output logic        strobe_a,
    output logic        strobe_b,
    output logic        bit_err,
    output logic        link_ok
`ifdef YMRX_MIX_EN
    ,
    output logic [15:0] mix,
    output logic        mix_strobe
`endif
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    // Pin bundle order: {data, smp[1], smp[0], dclk}
    logic [3:0]                    w_pin;
    logic [SYNC_STAGES-1:0][3:0]   r_sync;
    logic [3:0]                    w_sync;
    logic [2:0]                    r_hist;
    logic                          w_dclk_fall;
    logic [1:0]                    w_smp_fall;
    logic                          w_latch;
    logic                          w_data;

    logic [15:0]    r_shift;
    logic [4:0]     r_cnt;
    logic [WDW-1:0] r_wd;
    logic [15:0]    r_sample_a;
    logic [15:0]    r_sample_b;
    logic           r_strobe_a;
    logic           r_strobe_b;
    logic           r_bit_err;
    logic           r_link_ok;

    always_comb begin
        w_pin       = {ym_data, ym_smp, ym_dclk};
        w_sync      = r_sync[SYNC_STAGES-1];
        w_dclk_fall = r_hist[0] & ~w_sync[0];
        w_smp_fall  = r_hist[2:1] & ~w_sync[2:1];
        w_latch     = |w_smp_fall;
        w_data      = w_sync[3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= '0;
            r_hist     <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_wd       <= '0;
            r_sample_a <= '0;
            r_sample_b <= '0;
            r_strobe_a <= 1'b0;
            r_strobe_b <= 1'b0;
            r_bit_err  <= 1'b0;
            r_link_ok  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin};
            r_hist <= w_sync[2:0];

            if (w_dclk_fall)
                r_shift <= {r_shift[14:0], w_data};

            // A latch coinciding with a dclk fall takes the pre-shift word; that bit starts the next count.
            if (w_latch)
                r_cnt <= w_dclk_fall ? 5'd1 : 5'd0;
            else if (w_dclk_fall && r_cnt != 5'd31)
                r_cnt <= r_cnt + 5'd1;

            if (w_smp_fall[0])
                r_sample_a <= r_shift;
            if (w_smp_fall[1])
                r_sample_b <= r_shift;
            r_strobe_a <= w_smp_fall[0];
            r_strobe_b <= w_smp_fall[1];
            r_bit_err  <= w_latch && (r_cnt < 5'd16);

            if (w_dclk_fall)
                r_wd <= '0;
            else if (r_wd != WDW'(TIMEOUT))
                r_wd <= r_wd + 1'b1;

            // Link drops on the same edge the watchdog reaches TIMEOUT.
            if (!w_dclk_fall && r_wd >= WDW'(TIMEOUT - 1))
                r_link_ok <= 1'b0;
            else if (w_latch && r_wd < WDW'(TIMEOUT))
                r_link_ok <= 1'b1;
        end
    end

    assign sample_a = r_sample_a;
    assign sample_b = r_sample_b;
    assign strobe_a = r_strobe_a;
    assign strobe_b = r_strobe_b;
    assign bit_err  = r_bit_err;
    assign link_ok  = r_link_ok;

`ifdef YMRX_MIX_EN
    logic [16:0] w_sum;
    logic [15:0] r_mix;
    logic        r_mix_strobe;

    always_comb begin
        w_sum = {r_sample_a[15], r_sample_a} + {r_sample_b[15], r_sample_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mix        <= '0;
            r_mix_strobe <= 1'b0;
        end else begin
            r_mix_strobe <= r_strobe_b;
            if (r_strobe_b)
                r_mix <= w_sum[16:1];
        end
    end

    assign mix        = r_mix;
    assign mix_strobe = r_mix_strobe;
`endif

endmodule

// File: tb/tb_ymf262_rx.sv
`timescale 1ns/1ps
// Directed self-checking bench for ymf262_rx: framing, reset, watchdog, coincident edges, latency, optional mix.
module tb_ymf262_rx;

    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 256;
    localparam logic [17:0] WORD = 18'b111100001010101000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ym_dclk;
    logic [1:0]  ym_smp;
    logic        ym_data;
    logic [15:0] sample_a;
    logic [15:0] sample_b;
    logic        strobe_a;
    logic        strobe_b;
    logic        bit_err;
    logic        link_ok;
`ifdef YMRX_MIX_EN
    logic [15:0] mix;
    logic        mix_strobe;
`endif

    ymf262_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ym_dclk (ym_dclk),
        .ym_smp  (ym_smp),
        .ym_data (ym_data),
        .sample_a(sample_a),
        .sample_b(sample_b),
        .strobe_a(strobe_a),
        .strobe_b(strobe_b),
        .bit_err (bit_err),
        .link_ok (link_ok)
`ifdef YMRX_MIX_EN
        ,
        .mix       (mix),
        .mix_strobe(mix_strobe)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int asserts  = 0;
    int failures = 0;

    int          na = 0, nb = 0, nerr = 0, nmix = 0;
    logic [15:0] a_val = '0, b_val = '0, mix_val = '0;
    logic        a_err = 1'b0, b_err = 1'b0, a_link = 1'b0;
    int unsigned a_cyc = 0, b_cyc = 0, mix_cyc = 0;
    int unsigned last_fall_cyc = 0;

    // Event recorder: captures output state at each strobe.
    always @(negedge clk) begin
        if (strobe_a) begin
            na     <= na + 1;
            a_val  <= sample_a;
            a_err  <= bit_err;
            a_cyc  <= cyc;
            a_link <= link_ok;
        end
        if (strobe_b) begin
            nb    <= nb + 1;
            b_val <= sample_b;
            b_err <= bit_err;
            b_cyc <= cyc;
        end
        if (bit_err)
            nerr <= nerr + 1;
`ifdef YMRX_MIX_EN
        if (mix_strobe) begin
            nmix    <= nmix + 1;
            mix_val <= mix;
            mix_cyc <= cyc;
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One dclk period (clk/8): data and smp change with the rising edge.
    task automatic drive_period(input logic d, input logic [1:0] smp);
        ym_dclk = 1'b1;
        ym_data = d;
        ym_smp  = smp;
        repeat (4) tick();
        ym_dclk = 1'b0;
        last_fall_cyc = cyc;
        repeat (4) tick();
    endtask

    task automatic run_frame(input int rst_at, output logic [35:0] snap);
        logic [17:0] word_v;
        word_v = WORD;
        snap = '1;
        for (int k = 0; k < 36; k++) begin
            int w;
            logic [1:0] s;
            w = k % 18;
            s = {(k >= 25 && k <= 33), (k >= 7 && k <= 15)};
            if (k == rst_at) begin
                ym_dclk = 1'b1;
                ym_data = word_v[17-w];
                ym_smp  = s;
                reset   = 1'b1;
                tick();
                tick();
                snap = {sample_a, sample_b, strobe_a, strobe_b, bit_err, link_ok};
                tick();
                reset = 1'b0;
                tick();
                ym_dclk = 1'b0;
                last_fall_cyc = cyc;
                repeat (4) tick();
            end else begin
                drive_period(word_v[17-w], s);
            end
        end
    endtask

    task automatic shift_bits(input logic [15:0] w, input int nbits, input logic [1:0] smp);
        for (int i = nbits - 1; i >= 0; i--)
            drive_period(w[i], smp);
    endtask

    task automatic drop_smp();
        ym_smp = 2'b00;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        ym_dclk = 1'b0;
        ym_smp  = 2'b00;
        ym_data = 1'b0;
        repeat (3) tick();
        asserts++; if (sample_a !== 16'h0000) begin failures++; $display("FAIL reset_sample_a: got %h expected 0000", sample_a); end
        asserts++; if (sample_b !== 16'h0000) begin failures++; $display("FAIL reset_sample_b: got %h expected 0000", sample_b); end
        asserts++; if (strobe_a !== 1'b0) begin failures++; $display("FAIL reset_strobe_a: got %b expected 0", strobe_a); end
        asserts++; if (strobe_b !== 1'b0) begin failures++; $display("FAIL reset_strobe_b: got %b expected 0", strobe_b); end
        asserts++; if (bit_err !== 1'b0) begin failures++; $display("FAIL reset_bit_err: got %b expected 0", bit_err); end
        asserts++; if (link_ok !== 1'b0) begin failures++; $display("FAIL reset_link_ok: got %b expected 0", link_ok); end
`ifdef YMRX_MIX_EN
        asserts++; if (mix !== 16'h0000) begin failures++; $display("FAIL reset_mix: got %h expected 0000", mix); end
        asserts++; if (mix_strobe !== 1'b0) begin failures++; $display("FAIL reset_mix_strobe: got %b expected 0", mix_strobe); end
`endif
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_frames();
        int na0, nb0, ne0;
        logic [35:0] snap;
        na0 = na; nb0 = nb; ne0 = nerr;
        // First frame after reset: exactly 16 falls before the A latch, so no error.
        run_frame(-1, snap);
        asserts++; if (na !== na0 + 1) begin failures++; $display("FAIL frame1_strobe_a_count: got %0d expected %0d", na, na0 + 1); end
        asserts++; if (nb !== nb0 + 1) begin failures++; $display("FAIL frame1_strobe_b_count: got %0d expected %0d", nb, nb0 + 1); end
        asserts++; if (a_val !== 16'hF0AA) begin failures++; $display("FAIL frame1_sample_a: got %h expected f0aa", a_val); end
        asserts++; if (b_val !== 16'hF0AA) begin failures++; $display("FAIL frame1_sample_b: got %h expected f0aa", b_val); end
        asserts++; if (a_err !== 1'b0) begin failures++; $display("FAIL frame1_bit_err_16bits: got %b expected 0", a_err); end
        asserts++; if (!(a_cyc < b_cyc)) begin failures++; $display("FAIL frame1_order: a at %0d, b at %0d, expected a before b", a_cyc, b_cyc); end
        asserts++; if (link_ok !== 1'b1) begin failures++; $display("FAIL frame1_link_ok: got %b expected 1", link_ok); end
        repeat (2) run_frame(-1, snap);
        asserts++; if (na !== na0 + 3) begin failures++; $display("FAIL frames_strobe_a_count: got %0d expected %0d", na, na0 + 3); end
        asserts++; if (nb !== nb0 + 3) begin failures++; $display("FAIL frames_strobe_b_count: got %0d expected %0d", nb, nb0 + 3); end
        asserts++; if (nerr !== ne0) begin failures++; $display("FAIL frames_bit_err_count: got %0d expected %0d", nerr, ne0); end
        asserts++; if (a_val !== 16'hF0AA || b_val !== 16'hF0AA) begin failures++; $display("FAIL frames_samples: got %h/%h expected f0aa/f0aa", a_val, b_val); end
    endtask

    task automatic test_reset_midword();
        logic [35:0] snap;
        int ne0;
        run_frame(4, snap);
        asserts++; if (snap !== 36'h0) begin failures++; $display("FAIL midreset_outputs: got %h expected 000000000", snap); end
        asserts++; if (a_err !== 1'b1) begin failures++; $display("FAIL midreset_bit_err: got %b expected 1", a_err); end
        asserts++; if (a_val !== 16'h00AA) begin failures++; $display("FAIL midreset_partial_a: got %h expected 00aa", a_val); end
        asserts++; if (b_val !== 16'hF0AA || b_err !== 1'b0) begin failures++; $display("FAIL midreset_b: got %h err %b expected f0aa err 0", b_val, b_err); end
        ne0 = nerr;
        run_frame(-1, snap);
        asserts++; if (a_val !== 16'hF0AA || nerr !== ne0) begin failures++; $display("FAIL midreset_recovery: got %h errs %0d expected f0aa errs %0d", a_val, nerr, ne0); end
    endtask

    task automatic test_timeout();
        logic [35:0] snap;
        int unsigned delta;
        bit found;
        int na0;
        found = 1'b0;
        delta = 0;
        asserts++; if (link_ok !== 1'b1) begin failures++; $display("FAIL timeout_pre_link: got %b expected 1", link_ok); end
        for (int i = 0; i < 400; i++) begin
            tick();
            if (link_ok === 1'b0) begin
                found = 1'b1;
                delta = cyc - last_fall_cyc;
                break;
            end
        end
        // Pin fall reaches the detector SYNC_STAGES+1 clk later; the watchdog then runs TIMEOUT clk.
        asserts++;
        if (!found) begin failures++; $display("FAIL timeout_drop: link_ok still %b after 400 clk, expected 0", link_ok); end
        else if (delta != SYNC_STAGES + 1 + TIMEOUT) begin failures++; $display("FAIL timeout_drop: got %0d clk expected %0d", delta, SYNC_STAGES + 1 + TIMEOUT); end
        repeat (3) drive_period(1'b0, 2'b00);
        asserts++; if (link_ok !== 1'b0) begin failures++; $display("FAIL timeout_no_strobe_yet: got %b expected 0", link_ok); end
        na0 = na;
        run_frame(-1, snap);
        asserts++; if (na !== na0 + 1 || a_link !== 1'b1) begin failures++; $display("FAIL timeout_restore: strobes %0d link %b expected %0d link 1", na, a_link, na0 + 1); end
        asserts++; if (a_val !== 16'hF0AA) begin failures++; $display("FAIL timeout_restore_sample: got %h expected f0aa", a_val); end
    endtask

    task automatic test_simultaneous();
        int na0, nb0;
        logic [15:0] w2;
        w2 = 16'hC3A5;
        na0 = na; nb0 = nb;
        shift_bits(16'h1234, 16, 2'b11);
        // Both smp bits and dclk fall together: pre-shift word latched, MSB of w2 shifts in.
        ym_dclk = 1'b1;
        ym_data = w2[15];
        ym_smp  = 2'b11;
        repeat (4) tick();
        ym_dclk = 1'b0;
        ym_smp  = 2'b00;
        repeat (4) tick();
        asserts++; if (na !== na0 + 1 || nb !== nb0 + 1) begin failures++; $display("FAIL simul_counts: got %0d/%0d expected %0d/%0d", na, nb, na0 + 1, nb0 + 1); end
        asserts++; if (a_cyc !== b_cyc) begin failures++; $display("FAIL simul_same_cycle: a at %0d b at %0d expected equal", a_cyc, b_cyc); end
        asserts++; if (a_val !== 16'h1234 || b_val !== 16'h1234) begin failures++; $display("FAIL simul_values: got %h/%h expected 1234/1234", a_val, b_val); end
        asserts++; if (a_err !== 1'b0) begin failures++; $display("FAIL simul_bit_err: got %b expected 0", a_err); end
        shift_bits(w2, 15, 2'b01);
        drop_smp();
        asserts++; if (a_val !== 16'hC3A5) begin failures++; $display("FAIL coincident_shift: got %h expected c3a5", a_val); end
        asserts++; if (a_err !== 1'b0) begin failures++; $display("FAIL coincident_count: got bit_err %b expected 0", a_err); end
        shift_bits(16'h5A5A, 15, 2'b01);
        drop_smp();
        asserts++; if (a_err !== 1'b1) begin failures++; $display("FAIL short_word_15: got bit_err %b expected 1", a_err); end
    endtask

    task automatic test_latency();
        int unsigned t0, lat;
        bit found;
        found = 1'b0;
        lat = 0;
        ym_smp = 2'b01;
        repeat (6) tick();
        t0 = cyc;
        ym_smp = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (strobe_a === 1'b1) begin
                found = 1'b1;
                lat = cyc - t0;
                break;
            end
        end
        asserts++;
        if (!found) begin failures++; $display("FAIL latency: no strobe_a within 10 clk, expected after %0d", SYNC_STAGES + 1); end
        else if (lat != SYNC_STAGES + 1) begin failures++; $display("FAIL latency: got %0d clk expected %0d", lat, SYNC_STAGES + 1); end
        tick();
        asserts++; if (strobe_a !== 1'b0) begin failures++; $display("FAIL strobe_width: got %b expected 0", strobe_a); end
    endtask

    task automatic test_mix();
`ifdef YMRX_MIX_EN
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] vm [4];
        int nm0;
        va = '{16'h7FFF, 16'h8000, 16'h0001, 16'hF0AA};
        vb = '{16'h7FFF, 16'h8000, 16'hFFFE, 16'hF0AA};
        vm = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hF0AA};
        for (int i = 0; i < 4; i++) begin
            nm0 = nmix;
            shift_bits(va[i], 16, 2'b01);
            drop_smp();
            shift_bits(vb[i], 16, 2'b10);
            drop_smp();
            asserts++; if (nmix !== nm0 + 1 || mix_val !== vm[i]) begin failures++; $display("FAIL mix_%0d: got %h (strobes %0d) expected %h (strobes %0d)", i, mix_val, nmix, vm[i], nm0 + 1); end
            asserts++; if (mix_cyc !== b_cyc + 1) begin failures++; $display("FAIL mix_strobe_timing_%0d: got %0d expected %0d", i, mix_cyc, b_cyc + 1); end
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_frames();
        test_reset_midword();
        test_timeout();
        test_simultaneous();
        test_latency();
        test_mix();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
